// File: rtl/bench_core_arbiter.sv
// bench_core_arbiter: round-robin front end that shares one combinational
// benchmark core among NREQ requesters, one transaction at a time.
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   req_valid/ready  per-requester request handshake (ready is combinational)
//   req_data         request vectors, requester k at [k*IW +: IW]
//   core_pi/core_po  registered drive to the core / its combinational outputs
//   rsp_valid/ready  response handshake; rsp_data and rsp_id held until accepted
//   busy             high while a transaction is in DRIVE or RESP
//   txn_cnt          completed-transaction counter (wraps)
module bench_core_arbiter #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned IW     = 34,
    parameter int unsigned OW     = 10,
    parameter int unsigned SETTLE = 2,
    parameter int unsigned IDW    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*IW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [IW-1:0]        core_pi,
    input  logic [OW-1:0]        core_po,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [OW-1:0]        rsp_data,
    output logic [IDW-1:0]       rsp_id,
    output logic                 busy,
    output logic [15:0]          txn_cnt
);

    localparam int unsigned CW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int unsigned TCW = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_RESP  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    core_pi_q, core_pi_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [OW-1:0]    rsp_data_q, rsp_data_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [TCW-1:0]   txn_cnt_q, txn_cnt_d;
    logic             busy_q, busy_d;

    logic             gnt_found;
    logic [IDW-1:0]   gnt_idx;
    logic [IDW-1:0]   cand;
    logic             hs;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping mod NREQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = IDW'((32'(rr_ptr_q) + i) % NREQ);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // A grant is only offered from IDLE and never while reset is held.
    assign hs = (state_q == S_IDLE) && gnt_found && !rst;

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            core_pi_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            txn_cnt_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            core_pi_q   <= core_pi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            txn_cnt_q   <= txn_cnt_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (hs) state_d = S_DRIVE;
            S_DRIVE: if (cnt_q == '0) state_d = S_RESP;
            S_RESP:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values.
    always_comb begin
        req_ready   = '0;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        core_pi_d   = core_pi_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        txn_cnt_d   = txn_cnt_q;
        busy_d      = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (hs) begin
                    req_ready[gnt_idx] = 1'b1;
                    core_pi_d          = req_data[gnt_idx*IW +: IW];
                    rsp_id_d           = gnt_idx;
                    cnt_d              = CW'(SETTLE - 1);
                end
            end
            S_DRIVE: begin
                // core_pi has been stable SETTLE cycles when cnt reaches zero.
                if (cnt_q == '0) begin
                    rsp_data_d  = core_po;
                    rsp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rr_ptr_d    = (rsp_id_q == IDW'(NREQ - 1)) ? '0 : rsp_id_q + IDW'(1);
                    txn_cnt_d   = txn_cnt_q + TCW'(1);
                end
            end
            default: ;
        endcase
    end

    assign core_pi   = core_pi_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign txn_cnt   = txn_cnt_q;
    assign busy      = busy_q;

endmodule
